mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single CPU-side memory bus between the instruction-fetch port and the data (load/store) port.
- Applies kseg0/kseg1 virtual-to-physical mapping to the granted address.
- Flags kseg1 accesses as uncached.
- Sequences one outstanding transaction at a time; sits between the pipeline's IF/MEM stages and the cache/AXI bridge.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held stable until inst_addr_ok
- inst_addr  in  32  fetch virtual address
- inst_addr_ok  out  1  one-cycle pulse: fetch address accepted by memory
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request; held stable until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables (stores)
- data_addr  in  32  data virtual address
- data_wdata  in  32  store data
- data_addr_ok  out  1  one-cycle pulse: data address accepted
- data_data_ok  out  1  one-cycle pulse: load data valid / store complete
- data_rdata  out  32  load data
- mem_req  out  1  bus request
- mem_wr  out  1  registered data_wr (0 for fetch)
- mem_size  out  2  registered size (2 for fetch)
- mem_wstrb  out  4  registered strobes (0 for fetch)
- mem_addr  out  32  registered physical address
- mem_wdata  out  32  registered store data
- mem_uncached  out  1  1 when the source VA is in kseg1
- mem_addr_ok  in  1  bus accepted address this cycle
- mem_data_ok  in  1  bus response this cycle
- mem_rdata  in  32  bus read data

Behaviour:
- FSM states: IDLE, ADDR, WAIT. Reset or any rst cycle forces IDLE.
- Reset values: all outputs 0, starve counter 0, grant owner = none.
- IDLE:
  - If either request is high, pick a winner.
  - Data wins unless inst_req is high and the counter equals STARVE_LIMIT, in which case inst wins.
  - Capture the winner's fields into the mem_* registers and go to ADDR.
  - Latency: request sampled in cycle N gives mem_req=1 in cycle N+1.
- ADDR:
  - mem_req=1; all mem_* fields held stable.
  - When mem_addr_ok: pulse the winner's *_addr_ok in the same cycle, drop mem_req next cycle, go to WAIT.
- WAIT:
  - When mem_data_ok: route mem_rdata combinationally to the winner's *_rdata and pulse its *_data_ok in the same cycle, then go to IDLE.
  - One idle bubble between transactions; no pipelining of a second address.
- Non-granted port: its *_addr_ok and *_data_ok stay 0; its rdata output is don't-care (drive 0).
- Starvation counter:
  - Increments when data is granted while inst_req=1; saturates at STARVE_LIMIT.
  - Clears when inst is granted or when inst_req=0 at grant.
- Address mapping, applied at grant:
  - VA[31:29]=3'b100 (kseg0): PA = {3'b000, VA[28:0]}, mem_uncached=0.
  - VA[31:29]=3'b101 (kseg1): PA = {3'b000, VA[28:0]}, mem_uncached=1.
  - Any other VA: PA = VA, mem_uncached=0.
- mem_addr_ok or mem_data_ok arriving in IDLE, or mem_data_ok in ADDR, is ignored (stale response after reset). No error is raised.
- Requester dropping req before its addr_ok is illegal. Once granted, the transaction completes from the registered copy regardless.
- rst asserted mid-transaction: return to IDLE next cycle; no ok pulses are emitted for the aborted transaction.

Decomposition:
- Shared package holds:
  - KSEG0_TAG=3'b100 and KSEG1_TAG=3'b101.
  - Size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - FSM state encoding for IDLE/ADDR/WAIT.
- One sub-module, mem_addr_map: combinational VA to {PA, uncached}, used at the grant mux.

Test Plan:
- Inst only: inst_req=1, inst_addr=0xBFC00000; mem_addr_ok at +2, mem_data_ok with mem_rdata=0x3C080001 at +4. Required: mem_addr=0x1FC00000, mem_uncached=1, mem_size=2, inst_data_ok pulse with inst_rdata=0x3C080001.
- Simultaneous: inst_req and data_req high in the same IDLE cycle, data_addr=0x80001000, load. Required: data granted first with mem_addr=0x00001000, mem_uncached=0; inst granted on the next IDLE.
- Starvation: inst_req held high while data_req re-asserts continuously. Required: after 4 data grants, the 5th grant goes to inst and the counter returns to 0.
- Store passthrough: data_wr=1, data_addr=0x00400010 (kuseg), data_wstrb=4'b0011, data_size=1, data_wdata=0x0000BEEF. Required: mem_addr=0x00400010 unchanged, mem_wstrb=4'b0011, mem_wr=1; data_data_ok pulses on mem_data_ok.
- Reset in WAIT: assert rst for 1 cycle while awaiting data, then drive mem_data_ok. Required: all outputs 0, state IDLE, no *_data_ok pulse.
- Back-pressure: hold mem_addr_ok=0 for 5 cycles. Required: mem_req and all mem_* fields stable for those 5 cycles; *_addr_ok pulses only on the accept cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the CPU memory-bus arbiter: segment tags, access
// sizes, FSM/owner encodings and the registered bus command.
package mem_bus_arbiter_pkg;

  localparam logic [2:0] KSEG0_TAG = 3'b100;
  localparam logic [2:0] KSEG1_TAG = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncached;
  } mem_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation; kseg1 is
// additionally flagged as uncached.
module mem_addr_map
  import mem_bus_arbiter_pkg::*;
(
  input  logic [31:0] va,
  output logic [31:0] pa,
  output logic        uncached
);

  always_comb begin
    pa       = va;
    uncached = 1'b0;
    case (va[31:29])
      KSEG0_TAG: pa = {3'b000, va[28:0]};
      KSEG1_TAG: begin
        pa       = {3'b000, va[28:0]};
        uncached = 1'b1;
      end
      default: pa = va;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between fetch and load/store ports,
// one outstanding transaction at a time, with starvation protection for fetch.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncached,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  owner_t           owner, owner_nxt;
  mem_cmd_t         cmd, cmd_nxt;
  logic             req_q, req_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        grant_inst;
  logic [31:0] sel_va;
  logic [31:0] sel_pa;
  logic        sel_unc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == LIMIT) ? c : c + 1'b1;
  endfunction

  // Data wins by default; fetch wins alone or once data has starved it long enough
  assign grant_inst = inst_req && (!data_req || (cnt == LIMIT));
  assign sel_va     = grant_inst ? inst_addr : data_addr;

  mem_addr_map u_addr_map (
    .va       (sel_va),
    .pa       (sel_pa),
    .uncached (sel_unc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      req_q <= 1'b0;
      cnt   <= '0;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      req_q <= req_nxt;
      cnt   <= cnt_nxt;
      cmd   <= cmd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    req_nxt      = req_q;
    cnt_nxt      = cnt;
    cmd_nxt      = cmd;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    case (state)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          state_nxt = ST_ADDR;
          req_nxt   = 1'b1;
          if (grant_inst) begin
            owner_nxt = OWN_INST;
            cnt_nxt   = '0;
            cmd_nxt   = '{wr: 1'b0, size: SZ_WORD, wstrb: 4'h0, addr: sel_pa,
                          wdata: 32'h0, uncached: sel_unc};
          end else begin
            owner_nxt = OWN_DATA;
            cnt_nxt   = inst_req ? sat_inc(cnt) : '0;
            cmd_nxt   = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                          addr: sel_pa, wdata: data_wdata, uncached: sel_unc};
          end
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) begin
          state_nxt    = ST_WAIT;
          req_nxt      = 1'b0;
          inst_addr_ok = !rst && (owner == OWN_INST);
          data_addr_ok = !rst && (owner == OWN_DATA);
        end
      end
      ST_WAIT: begin
        if (mem_data_ok) begin
          state_nxt    = ST_IDLE;
          owner_nxt    = OWN_NONE;
          inst_data_ok = !rst && (owner == OWN_INST);
          data_data_ok = !rst && (owner == OWN_DATA);
          inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
          data_rdata   = data_data_ok ? mem_rdata : 32'h0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_req      = req_q;
  assign mem_wr       = cmd.wr;
  assign mem_size     = cmd.size;
  assign mem_wstrb    = cmd.wstrb;
  assign mem_addr     = cmd.addr;
  assign mem_wdata    = cmd.wdata;
  assign mem_uncached = cmd.uncached;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration and mapping.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_uncached, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester/model state: pending requests and the starvation count
  bit          inst_pend = 0, data_pend = 0;
  logic [31:0] ia = '0, da = '0, dwd = '0;
  logic        dwr = 1'b0;
  logic [1:0]  dsz = '0;
  logic [3:0]  dst = '0;
  int          mcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic void map_va(input logic [31:0] va, output logic [31:0] pa, output logic unc);
    if (va < 32'h8000_0000 || va >= 32'hC000_0000) begin
      pa = va; unc = 1'b0;
    end else if (va < 32'hA000_0000) begin
      pa = va - 32'h8000_0000; unc = 1'b0;
    end else begin
      pa = va - 32'hA000_0000; unc = 1'b1;
    end
  endfunction

  task automatic check_cmd(input string tag, input logic req, input logic wr, input logic [1:0] sz,
                           input logic [3:0] st, input logic [31:0] a, input logic [31:0] wd,
                           input logic unc);
    check_eq({tag, ".mem_req"}, mem_req, req);
    check_eq({tag, ".mem_wr"}, mem_wr, wr);
    check_eq({tag, ".mem_size"}, mem_size, sz);
    check_eq({tag, ".mem_wstrb"}, mem_wstrb, st);
    check_eq({tag, ".mem_addr"}, mem_addr, a);
    check_eq({tag, ".mem_wdata"}, mem_wdata, wd);
    check_eq({tag, ".mem_uncached"}, mem_uncached, unc);
  endtask

  function automatic logic [31:0] rand_va();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return {3'b100, r[28:0]};
      1: return {3'b101, r[28:0]};
      2: return {1'b0, r[30:0]};
      default: return {2'b11, r[29:0]};
    endcase
  endfunction

  task automatic drive_reqs();
    inst_req = inst_pend; inst_addr = ia;
    data_req = data_pend; data_addr = da; data_wr = dwr;
    data_size = dsz; data_wstrb = dst; data_wdata = dwd;
  endtask

  // One full transaction from the IDLE cycle; entered and left at posedge+1
  task automatic run_txn(input bit ni, input logic [31:0] nia, input bit nd, input logic nwr,
                         input logic [1:0] nsz, input logic [3:0] nst, input logic [31:0] nda,
                         input logic [31:0] nwd, input int aw, input int dw,
                         input logic [31:0] rd, input bit abort, input bit stale);
    bit          win_inst;
    logic [31:0] ea, ewd;
    logic        eu, ewr;
    logic [1:0]  esz;
    logic [3:0]  est;
    if (ni) begin inst_pend = 1; ia = nia; end
    if (nd) begin data_pend = 1; dwr = nwr; dsz = nsz; dst = nst; da = nda; dwd = nwd; end
    if (!inst_pend && !data_pend) return;
    drive_reqs();
    win_inst = inst_pend && (!data_pend || mcnt == LIMIT);
    if (win_inst || !inst_pend) mcnt = 0;
    else if (mcnt < LIMIT) mcnt = mcnt + 1;
    if (win_inst) begin
      map_va(ia, ea, eu); ewr = 0; esz = SZ_WORD; est = 0; ewd = 0;
    end else begin
      map_va(da, ea, eu); ewr = dwr; esz = dsz; est = dst; ewd = dwd;
    end
    @(posedge clk); #1;
    for (int i = 0; i <= aw; i++) begin
      mem_addr_ok = (i == aw);
      mem_data_ok = stale && (i != aw);
      mem_rdata   = $urandom;
      if (!inst_pend) inst_addr = $urandom;
      if (!data_pend) data_addr = $urandom;
      #1;
      check_cmd("addr_phase", 1'b1, ewr, esz, est, ea, ewd, eu);
      check_eq("inst_addr_ok", inst_addr_ok, (i == aw) && win_inst);
      check_eq("data_addr_ok", data_addr_ok, (i == aw) && !win_inst);
      check_eq("inst_data_ok_addr", inst_data_ok, 1'b0);
      check_eq("data_data_ok_addr", data_data_ok, 1'b0);
      @(posedge clk); #1;
    end
    mem_addr_ok = 0; mem_data_ok = 0;
    if (win_inst) inst_pend = 0; else data_pend = 0;
    drive_reqs();
    #1;
    check_eq("mem_req_wait", mem_req, 1'b0);
    if (abort) begin
      inst_pend = 0; data_pend = 0; drive_reqs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0; mem_data_ok = 1; mem_rdata = rd;
      #1;
      check_eq("abort_inst_data_ok", inst_data_ok, 1'b0);
      check_eq("abort_data_data_ok", data_data_ok, 1'b0);
      check_eq("abort_inst_rdata", inst_rdata, 32'h0);
      check_eq("abort_data_rdata", data_rdata, 32'h0);
      check_cmd("abort", 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 32'h0, 1'b0);
      mcnt = 0;
      @(posedge clk); #1;
      mem_data_ok = 0;
      #1;
      check_eq("abort_idle_req", mem_req, 1'b0);
      return;
    end
    for (int i = 0; i <= dw; i++) begin
      mem_data_ok = (i == dw);
      mem_rdata   = (i == dw) ? rd : $urandom;
      #1;
      check_eq("mem_req_wait_loop", mem_req, 1'b0);
      check_eq("inst_data_ok", inst_data_ok, (i == dw) && win_inst);
      check_eq("data_data_ok", data_data_ok, (i == dw) && !win_inst);
      if (i == dw) begin
        check_eq("inst_rdata", inst_rdata, win_inst ? rd : 32'h0);
        check_eq("data_rdata", data_rdata, win_inst ? 32'h0 : rd);
      end
      @(posedge clk); #1;
    end
    mem_data_ok = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (inst_pend || data_pend); k++)
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0, 0);
  endtask

  initial begin
    bit ni, nd;
    rst = 1; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1;
    check_cmd("reset", 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 32'h0, 1'b0);
    check_eq("reset_inst_addr_ok", inst_addr_ok, 1'b0);
    check_eq("reset_data_addr_ok", data_addr_ok, 1'b0);
    rst = 0;
    @(posedge clk); #1;

    // Fetch alone from kseg1 reset vector
    run_txn(1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3C08_0001, 0, 0);
    // Both at once: data first, fetch on the following IDLE
    run_txn(1, 32'h9FC0_0010, 1, 0, SZ_WORD, 4'hF, 32'h8000_1000, 0, 0, 0, $urandom, 0, 0);
    run_txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, 0, 0);
    // Starvation: data keeps re-requesting while fetch waits
    for (int i = 0; i < 6; i++)
      run_txn(!inst_pend, 32'hBFC0_0100, !data_pend, 0, SZ_WORD, 4'hF, 32'h8000_2000 + i * 4, 0,
              0, 0, $urandom, 0, 0);
    drain();
    // Store through kuseg with partial strobes
    run_txn(0, 0, 1, 1, SZ_HALF, 4'b0011, 32'h0040_0010, 32'h0000_BEEF, 0, 1, $urandom, 0, 0);
    // Back-pressure with stale data responses during the address phase
    run_txn(0, 0, 1, 0, SZ_BYTE, 4'b0001, 32'hA000_0040, 0, 5, 2, $urandom, 0, 1);
    // Reset while waiting for read data
    run_txn(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 1, 0);
    // Stray responses while idle
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("idle_stale_inst_addr_ok", inst_addr_ok, 1'b0);
    check_eq("idle_stale_data_data_ok", data_data_ok, 1'b0);
    @(posedge clk); #1;
    check_eq("idle_stale_mem_req", mem_req, 1'b0);
    mem_addr_ok = 0; mem_data_ok = 0;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      ni = !inst_pend && ($urandom_range(0, 99) < 60);
      nd = !data_pend && ($urandom_range(0, 99) < 75);
      if (!inst_pend && !data_pend && !ni && !nd) nd = 1;
      run_txn(ni, rand_va(), nd, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom), rand_va(),
              $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom, 0,
              $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
